md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline; owns the HI/LO register pair.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Holds a busy window of fixed length per operation.
- Issues a stall request to the D-stage control while any HI/LO-class instruction in D would collide with an operation in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (reset==0 at posedge clears state)
start  input  1  E-stage HI/LO-class instruction valid this cycle
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
B  input  32  rt operand (divisor / multiplier)
md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
hi  output  32  committed HI
lo  output  32  committed LO
busy  output  1  operation in flight
stall  output  1  D-stage stall request

Behaviour:
- Reset (reset==0 at posedge): hi=0, lo=0, busy=0, counter=0, state=IDLE. Applies mid-operation; the pending result is discarded and never written.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; 4-bit down-counter active.
- IDLE, start=1, md_op in {1,2}:
  - Compute the 64-bit product into pending regs (pend_hi=prod[63:32], pend_lo=prod[31:0]).
  - Signed for mult, unsigned for multu.
  - counter<=MULT_CYCLES; go to RUN.
- IDLE, start=1, md_op in {3,4}:
  - pend_lo=quotient, pend_hi=remainder; counter<=DIV_CYCLES; go to RUN.
  - Signed div truncates toward zero; the remainder takes the dividend's sign.
  - B==0: pend_lo=32'hFFFF_FFFF, pend_hi=A (both signed and unsigned).
  - Signed 32'h8000_0000 / 32'hFFFF_FFFF: pend_lo=32'h8000_0000, pend_hi=0.
- IDLE, start=1, md_op=5: hi<=A at the next edge. md_op=6: lo<=A. No busy; state stays IDLE.
- IDLE, start=1, md_op in {0,7}: no effect.
- RUN: the counter decrements each cycle. At the edge where counter==1:
  - hi<=pend_hi, lo<=pend_lo.
  - busy falls to 0 at that same edge; state returns to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
- hi/lo keep their old values throughout RUN. New values become visible in the cycle busy is first low.
- start=1 while in RUN is ignored; hi/lo/pending/counter are unaffected. The stall protocol makes this unreachable in legal code; the bench flags it as an assertion.
- stall = md_use_D & (busy | (start & md_op in {1,2,3,4})). Purely combinational from current inputs and state, with no registered delay.
- mthi/mtlo in E do not stall D; a D-stage mfhi issues one cycle later and reads the updated value.
- hi and lo change only at: reset, the completion edge, or an mthi/mtlo edge.
- Completion edge coinciding with start=1 in the same cycle: completion commits first. The start is ignored because the state is still RUN at that edge.

Test Plan:
1. Reset low 2 cycles, then high -> hi=0, lo=0, busy=0, stall=0.
2. mult A=32'hFFFF_FFFE (-2), B=3 -> busy high exactly 5 cycles; hi/lo unchanged during the window; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. The multu repeat gives hi=32'h0000_0002, lo=32'hFFFF_FFFA.
3. div A=-7 (32'hFFFF_FFF9), B=2 -> busy 10 cycles, lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. div with B=0, A=5 -> lo=32'hFFFF_FFFF, hi=5.
4. Stall:
   - md_use_D=1 held during div -> stall=1 in the start cycle and all 10 busy cycles; 0 the cycle after completion.
   - md_use_D=0 -> stall=0 throughout.
5. mthi A=32'h1234_5678, then mtlo A=32'hCAFE_0000 on consecutive cycles -> hi/lo update on the respective next edges, busy stays 0; a second start during RUN leaves the final result unchanged.
6. Reset asserted at busy cycle 3 of mult -> hi=lo=0, busy=0 next cycle; pending product is never committed.

Source files
------------

// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler: computes the result at issue, holds it in
// pending registers for a fixed busy window, then commits it to HI/LO.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);
  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] hi_d, lo_d;

  logic        is_mul, is_div, sgn_op;
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign is_mul = (md_op == 3'd1) || (md_op == 3'd2);
  assign is_div = (md_op == 3'd3) || (md_op == 3'd4);
  assign sgn_op = (md_op == 3'd1) || (md_op == 3'd3);

  always_comb begin
    if (sgn_op) prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    else        prod = {32'b0, A} * {32'b0, B};
  end

  // Signed divide on magnitudes; quotient sign is the XOR, remainder follows the
  // dividend. The most-negative / -1 case wraps to 32'h8000_0000 on its own.
  assign a_neg  = sgn_op & A[31];
  assign b_neg  = sgn_op & B[31];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign b_safe = (B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;

  always_comb begin
    if (B == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = A;
    end else begin
      quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem  = a_neg ? -r_mag : r_mag;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi;
    lo_d      = lo;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul) begin
            pend_hi_d = prod[63:32];
            pend_lo_d = prod[31:0];
            cnt_d     = MUL_N;
            state_d   = S_RUN;
          end else if (is_div) begin
            pend_hi_d = rem;
            pend_lo_d = quot;
            cnt_d     = DIV_N;
            state_d   = S_RUN;
          end else if (md_op == 3'd5) begin
            hi_d = A;
          end else if (md_op == 3'd6) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        // Starts are ignored here, including on the completion edge itself.
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign stall = md_use_D & (busy | (start & (is_mul | is_div)));

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed vector table, hand sequences for stall/overlap/
// reset corners, and randomized traffic against an arithmetic reference model.
module tb_md_sched;
  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic        clk = 1'b0;
  logic        reset, start, md_use_D;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic [31:0] hi, lo;
  logic        busy, stall;

  md_sched #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .md_use_D(md_use_D), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit allow_ovl = 1'b0;

  // reference model: committed values, pending result, busy cycles remaining
  bit          m_valid = 1'b0;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          nbusy;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint sa, sb, ua, ub, p, q, r;
    sa = $signed(A);
    sb = $signed(B);
    ua = {32'b0, A};
    ub = {32'b0, B};
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_valid = 1'b1;
    end else if (m_left > 0) begin
      if (m_left == 1) begin m_hi = m_phi; m_lo = m_plo; end
      m_left--;
    end else if (start) begin
      case (md_op)
        3'd1, 3'd2: begin
          p = (md_op == 3'd1) ? sa * sb : ua * ub;
          m_phi = p[63:32]; m_plo = p[31:0]; m_left = MULT;
        end
        3'd3, 3'd4: begin
          if (B == 0) begin
            m_phi = A; m_plo = 32'hFFFF_FFFF;
          end else begin
            q = (md_op == 3'd3) ? sa / sb : ua / ub;
            r = (md_op == 3'd3) ? sa % sb : ua % ub;
            m_phi = r[31:0]; m_plo = q[31:0];
          end
          m_left = DIV;
        end
        3'd5: m_hi = A;
        3'd6: m_lo = A;
        default: ;
      endcase
    end
  endtask

  // one clock: compare everything mid-cycle, then advance the model on the edge
  task automatic tick();
    logic exp_stall;
    @(negedge clk);
    if (m_valid) begin
      exp_stall = md_use_D && ((m_left > 0) || (start && md_op >= 3'd1 && md_op <= 3'd4));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk)
    if (reset && !allow_ovl && m_valid)
      assert (!(start && busy && md_op >= 3'd1 && md_op <= 3'd6))
        else $error("start issued while an operation is in flight");

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  initial begin
    int nb, ns;
    logic [31:0] sv_hi, sv_lo;

    tbl[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT};
    tbl[1]  = '{3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, MULT};
    tbl[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV};
    tbl[3]  = '{3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV};
    tbl[4]  = '{3'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV};
    tbl[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV};
    tbl[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, DIV};
    tbl[7]  = '{3'd5, 32'h1234_5678, 32'd9,         32'h1234_5678, 32'h7FFF_FFFC, 0};
    tbl[8]  = '{3'd6, 32'hCAFE_0000, 32'd9,         32'h1234_5678, 32'hCAFE_0000, 0};
    tbl[9]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT};
    tbl[10] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT};
    tbl[11] = '{3'd7, 32'h1111_1111, 32'd2,         32'h4000_0000, 32'h0000_0000, 0};

    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0; md_use_D = 1'b0;
    tick(); tick();
    reset = 1'b1; md_use_D = 1'b1;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    md_use_D = 1'b0;

    // directed vectors: busy window length and committed HI/LO
    foreach (tbl[i]) begin
      start = 1'b1; md_op = tbl[i].op; A = tbl[i].a; B = tbl[i].b;
      tick();
      start = 1'b0;
      nb = 0;
      for (int k = 0; k < 20 && busy; k++) begin nb++; tick(); end
      chk($sformatf("vec%0d_busy", i), nb, tbl[i].nbusy);
      chk($sformatf("vec%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, tbl[i].lo);
    end

    // stall held across a divide with D-stage HI/LO use
    md_use_D = 1'b1; start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
    #1 chk("stall_start", {31'b0, stall}, 32'd1);
    tick();
    start = 1'b0; ns = 0;
    for (int k = 0; k < 20 && busy; k++) begin ns += stall; tick(); end
    chk("stall_window", ns, DIV);
    chk("stall_after", {31'b0, stall}, 32'd0);
    chk("div_100_7", {hi, lo} == {32'd2, 32'd14}, 32'd1);

    md_use_D = 1'b0; start = 1'b1; md_op = 3'd4; A = 32'd9; B = 32'd4;
    ns = stall;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && busy; k++) begin ns += stall; tick(); end
    chk("nostall", ns, 0);

    // start during RUN is ignored, including on the completion edge
    allow_ovl = 1'b1;
    start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd4;
    tick();
    md_op = 3'd3; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; md_op = 3'd5; A = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    chk("ovl_busy", {31'b0, busy}, 32'd0);
    chk("ovl_hi", hi, 32'd0);
    chk("ovl_lo", lo, 32'd12);
    allow_ovl = 1'b0;

    // reset in busy cycle 3 of a mult discards the pending product
    start = 1'b1; md_op = 3'd6; A = 32'h5555_AAAA;
    tick();
    md_op = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    sv_hi = hi; sv_lo = lo;
    for (int k = 0; k < 8; k++) tick();
    chk("rst_no_commit", {hi, lo} == 64'd0 && sv_hi == 32'd0 && sv_lo == 32'd0, 32'd1);

    // randomized traffic, overlapping starts allowed and modelled
    allow_ovl = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      reset    = ($urandom_range(0, 99) != 0);
      start    = ($urandom_range(0, 2) == 0);
      md_op    = 3'($urandom_range(0, 7));
      A        = pick();
      B        = pick();
      md_use_D = $urandom_range(0, 1) == 1;
      tick();
    end
    reset = 1'b1; start = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
